// File: rtl/mpte_lookaside_buffer.sv
// mpte_lookaside_buffer
//   Fully associative MPTE cache shared by every walking level of the MPT
//   walker. Entries are tagged {level, addr}. They are filled from memory-read
//   results and replaced round-robin once no free entry is left. A hit lets a
//   walk transaction skip its memory read.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   lookup_*                lookup request (valid/ready) carrying the level/addr tag
//   resp_*                  registered lookup response (valid/ready), hit flag + data
//   fill_*                  fill strobe with tag and data; there is no back-pressure
//   flush_req_i/flush_done_o  drain-then-clear flush handshake
//   hit_count_o/miss_count_o  saturating lookup statistics
//   flush_state_o           debug view of the flush FSM (0 IDLE,1 DRAIN,2 CLEAR,3 DONE)
//
// Handshake rule: a transfer happens on a rising clk_i edge where valid and
// ready are both high. While valid is high without ready, the sender keeps its
// payload stable. The response side holds resp_* stable until resp_ready_i.
module mpte_lookaside_buffer #(
   parameter int ADDR_WIDTH = 64,
   parameter int MPTE_WIDTH = 64,
   parameter int DEPTH      = 8,
   parameter int LEVELS     = 3,
   parameter int CNT_WIDTH  = 32,
   parameter int LW         = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  lookup_valid_i,
   output logic                  lookup_ready_o,
   input  logic [LW-1:0]         lookup_level_i,
   input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic                  resp_hit_o,
   output logic [MPTE_WIDTH-1:0] resp_mpte_o,
   input  logic                  fill_valid_i,
   input  logic [LW-1:0]         fill_level_i,
   input  logic [ADDR_WIDTH-1:0] fill_addr_i,
   input  logic [MPTE_WIDTH-1:0] fill_mpte_i,
   input  logic                  flush_req_i,
   output logic                  flush_done_o,
   output logic [CNT_WIDTH-1:0]  hit_count_o,
   output logic [CNT_WIDTH-1:0]  miss_count_o,
   output logic [1:0]            flush_state_o
);

   localparam int VPW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [DEPTH-1:0]      valid_q;
   logic [LW-1:0]         level_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
   logic [MPTE_WIDTH-1:0] mpte_q  [DEPTH];
   logic [VPW-1:0]        vp_q;

   logic                  resp_valid_q;
   logic                  resp_hit_q;
   logic [MPTE_WIDTH-1:0] resp_mpte_q;
   logic                  flush_done_q;
   logic [CNT_WIDTH-1:0]  hit_cnt_q;
   logic [CNT_WIDTH-1:0]  miss_cnt_q;

   logic                  lookup_fire;
   logic                  lk_hit;
   logic [MPTE_WIDTH-1:0] lk_mpte;

   logic                  fill_en;
   logic                  fill_hit;
   logic [VPW-1:0]        fill_hit_idx;
   logic                  free_found;
   logic [VPW-1:0]        free_idx;
   logic [VPW-1:0]        wr_idx;
   logic                  advance_vp;

   // Lookups are refused while reset is high, during a flush, and while an
   // unconsumed response occupies the single response register.
   assign lookup_ready_o = !rst_i && (state_q == IDLE) && (!resp_valid_q || resp_ready_i);
   assign lookup_fire    = lookup_valid_i && lookup_ready_o;

   assign resp_valid_o  = resp_valid_q;
   assign resp_hit_o    = resp_hit_q;
   assign resp_mpte_o   = resp_mpte_q;
   assign flush_done_o  = flush_done_q;
   assign hit_count_o   = hit_cnt_q;
   assign miss_count_o  = miss_cnt_q;
   assign flush_state_o = state_q;

   // Lookup compare. Fills update in place, so at most one entry can match
   // and OR-ing the matching data yields that entry's data, or zero on a miss.
   always_comb begin
      lk_hit  = 1'b0;
      lk_mpte = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (level_q[i] == lookup_level_i) && (addr_q[i] == lookup_addr_i)) begin
            lk_hit  = 1'b1;
            lk_mpte = lk_mpte | mpte_q[i];
         end
      end
   end

   // Fill target selection: the existing entry, else the lowest free slot,
   // else the round-robin victim.
   always_comb begin
      fill_hit     = 1'b0;
      fill_hit_idx = '0;
      free_found   = 1'b0;
      free_idx     = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = VPW'(i);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (level_q[i] == fill_level_i) && (addr_q[i] == fill_addr_i)) begin
            fill_hit     = 1'b1;
            fill_hit_idx = VPW'(i);
         end
      end
   end

   // Fills are dropped while the flush is draining or clearing.
   assign fill_en    = fill_valid_i && ((state_q == IDLE) || (state_q == DONE));
   assign wr_idx     = fill_hit ? fill_hit_idx : (free_found ? free_idx : vp_q);
   assign advance_vp = fill_en && !fill_hit && !free_found;

   // Tag/data storage needs no reset: every use is qualified by valid_q.
   // Rewriting level/addr on an in-place update stores the same values.
   always_ff @(posedge clk_i) begin
      if (fill_en) begin
         level_q[wr_idx] <= fill_level_i;
         addr_q[wr_idx]  <= fill_addr_i;
         mpte_q[wr_idx]  <= fill_mpte_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         vp_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_mpte_q  <= '0;
         flush_done_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         // Response register: a new lookup overwrites it. Otherwise it empties
         // once the consumer takes it.
         if (lookup_fire) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= lk_hit;
            resp_mpte_q  <= lk_mpte;
         end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_mpte_q  <= '0;
         end

         // Saturating statistics; a flush leaves them untouched.
         if (lookup_fire) begin
            if (lk_hit) begin
               if (hit_cnt_q != {CNT_WIDTH{1'b1}}) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end else begin
               if (miss_cnt_q != {CNT_WIDTH{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
         end

         // Entry valid bits and victim pointer. CLEAR and fill_en never coincide.
         if (state_q == CLEAR) begin
            valid_q <= '0;
            vp_q    <= '0;
         end else if (fill_en) begin
            valid_q[wr_idx] <= 1'b1;
            if (advance_vp) vp_q <= vp_q + VPW'(1);
         end

         // Flush FSM. Dropping flush_req_i early does not abort the flush.
         // DONE is then held for a single cycle.
         case (state_q)
            IDLE:  if (flush_req_i) state_q <= DRAIN;
            DRAIN: if (!resp_valid_q) state_q <= CLEAR;
            CLEAR: begin
               state_q      <= DONE;
               flush_done_q <= 1'b1;
            end
            DONE:  if (!flush_req_i) begin
               state_q      <= IDLE;
               flush_done_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
